// File: rtl/v_slot_sequencer_pkg.sv
// rtl/v_slot_sequencer_pkg.sv - shared types for the vector slot sequencer
//
// Purpose: sequencing modes, FSM states and the latched configuration flags
// used by v_slot_sequencer.
// Ports: none (package).
package v_slot_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'd0,
    MODE_WIDEN   = 2'd1,
    MODE_NARROW  = 2'd2,
    MODE_ILLEGAL = 2'd3
  } seq_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } seq_state_e;

  // Width-independent part of the latched configuration.
  typedef struct packed {
    seq_mode_e mode;
    logic      reduce;
    logic      err;
  } seq_cfg_t;

  // WIDEN and NARROW both scale addresses by 2^F and need a legal F.
  function automatic logic mode_uses_flog(input logic [1:0] mode);
    return (mode == MODE_WIDEN) || (mode == MODE_NARROW);
  endfunction

endpackage

// File: rtl/v_slot_be_gen.sv
// rtl/v_slot_be_gen.sv - in-range flag and byte enables for one element beat
//
// Purpose: combinational byte-enable selection for the element at idx.
// Ports:
//   idx, start_idx, end_idx  element index and inclusive active range
//   head_be, tail_be         enables for the first / last active element
//   in_range                 idx lies within [start_idx, end_idx]
//   be                       enables for this beat (0 outside the range)
module v_slot_be_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int BE_W       = 16
) (
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [ADDR_WIDTH-1:0] start_idx,
  input  logic [ADDR_WIDTH-1:0] end_idx,
  input  logic [BE_W-1:0]       head_be,
  input  logic [BE_W-1:0]       tail_be,
  output logic                  in_range,
  output logic [BE_W-1:0]       be
);

  always_comb begin
    in_range = (idx >= start_idx) && (idx <= end_idx);
    be       = '0;
    if (in_range) begin
      // A single-element range is both head and tail at once.
      if (start_idx == end_idx)  be = head_be & tail_be;
      else if (idx == start_idx) be = head_be;
      else if (idx == end_idx)   be = tail_be;
      else                       be = '1;
    end
  end

endmodule

// File: rtl/v_slot_sequencer.sv
// rtl/v_slot_sequencer.sv - per-slot element sequencer for the vector unit
//
// Purpose: walks [cfg_start, cfg_end] in BANK_COUNT-aligned blocks, one beat per
// out_valid/out_ready handshake, producing element index, writeback address,
// byte enables and bank source rows; supports widen, narrow, reduction, abort.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cfg_valid/cfg_ready            start request / accepted only in IDLE
//   cfg_mode, cfg_flog, cfg_reduce mode, log2 factor, reduction flag
//   cfg_start, cfg_end             inclusive element range
//   cfg_vs1, cfg_vs2, cfg_vd       initial source rows and writeback address
//   cfg_head_be, cfg_tail_be       first / last element byte enables
//   abort                          flush the running sequence
//   out_valid/out_ready            beat handshake
//   out_idx, out_turn, out_in_range, out_first, out_wb_addr, out_wb_be,
//   out_vs1, out_vs2               beat contents (zero when no beat)
//   busy, done, cfg_err            running, completion pulse, illegal cfg pulse
module v_slot_sequencer
  import v_slot_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH      = 128,
  parameter int BANK_COUNT      = 4,
  parameter int MAX_FLOG        = 2,
  localparam int BE_W           = DATA_WIDTH / 8,
  localparam int FLOG_W         = $clog2(MAX_FLOG + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [1:0]                 cfg_mode,
  input  logic [FLOG_W-1:0]          cfg_flog,
  input  logic                       cfg_reduce,
  input  logic [ADDR_WIDTH-1:0]      cfg_start,
  input  logic [ADDR_WIDTH-1:0]      cfg_end,
  input  logic [BANK_ADDR_WIDTH-1:0] cfg_vs1,
  input  logic [BANK_ADDR_WIDTH-1:0] cfg_vs2,
  input  logic [ADDR_WIDTH-1:0]      cfg_vd,
  input  logic [BE_W-1:0]            cfg_head_be,
  input  logic [BE_W-1:0]            cfg_tail_be,
  input  logic                       abort,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_idx,
  output logic [MAX_FLOG-1:0]        out_turn,
  output logic                       out_in_range,
  output logic                       out_first,
  output logic [ADDR_WIDTH-1:0]      out_wb_addr,
  output logic [BE_W-1:0]            out_wb_be,
  output logic [BANK_ADDR_WIDTH-1:0] out_vs1,
  output logic [BANK_ADDR_WIDTH-1:0] out_vs2,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int ALIGN = $clog2(BANK_COUNT);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(BANK_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_STEP = ADDR_WIDTH'(BANK_COUNT);

  seq_state_e                 state_q, state_d;
  seq_cfg_t                   cfg_q;
  logic [FLOG_W-1:0]          flog_q;
  logic [ADDR_WIDTH-1:0]      start_q, end_q, base_q, vd_q;
  logic [BANK_ADDR_WIDTH-1:0] vs1_q, vs2_q;
  logic [BE_W-1:0]            head_q, tail_q;
  logic [ADDR_WIDTH-1:0]      k_q;
  logic [MAX_FLOG-1:0]        turn_q;

  logic                       cfg_illegal, accept, run, advance;
  logic                       last_turn, turn_end, last_beat, in_range;
  logic [ADDR_WIDTH-1:0]      idx, wb_addr;
  logic [MAX_FLOG-1:0]        turn_max;
  logic [BE_W-1:0]            be;

  assign cfg_illegal = (cfg_mode == MODE_ILLEGAL)
                     || (mode_uses_flog(cfg_mode)
                         && ((cfg_flog == '0) || (cfg_flog > FLOG_W'(MAX_FLOG))))
                     || (cfg_end < cfg_start);

  assign accept   = (state_q == ST_IDLE) && cfg_valid;
  assign run      = (state_q == ST_RUN);
  assign advance  = run && out_ready && !abort;
  assign idx      = base_q + k_q;
  assign turn_max = MAX_FLOG'((1 << flog_q) - 1);

  // A widen turn ends at the last bank of the block or at the range end;
  // only the final turn of the final block ends the sequence.
  assign turn_end  = (idx == end_q) || (k_q[ALIGN-1:0] == '1);
  assign last_turn = (cfg_q.mode != MODE_WIDEN) || (turn_q == turn_max);
  assign last_beat = (idx == end_q) && last_turn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cfg_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = cfg_illegal ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // Abort beats a simultaneous final handshake: no done.
        if (abort)                       state_d = ST_IDLE;
        else if (out_ready && last_beat) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        cfg_err = cfg_q.err;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q   <= '{mode: MODE_NORMAL, reduce: 1'b0, err: 1'b0};
      flog_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      base_q  <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      k_q     <= '0;
      turn_q  <= '0;
    end else if (accept) begin
      cfg_q   <= '{mode: seq_mode_e'(cfg_mode), reduce: cfg_reduce, err: cfg_illegal};
      flog_q  <= cfg_flog;
      start_q <= cfg_start;
      end_q   <= cfg_end;
      base_q  <= cfg_start & ~BLK_MASK;
      vd_q    <= cfg_vd;
      vs1_q   <= cfg_vs1;
      vs2_q   <= cfg_vs2;
      head_q  <= cfg_head_be;
      tail_q  <= cfg_tail_be;
      k_q     <= '0;
      turn_q  <= '0;
    end else if (advance) begin
      if ((cfg_q.mode == MODE_WIDEN) && turn_end) begin
        if (turn_q == turn_max) begin
          turn_q <= '0;
          k_q    <= (k_q & ~BLK_MASK) + BLK_STEP;
        end else begin
          turn_q <= turn_q + MAX_FLOG'(1);
          k_q    <= k_q & ~BLK_MASK;
        end
      end else begin
        k_q <= k_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Widen: vd + (blk*BANK_COUNT + j)*W + t, and blk*BANK_COUNT + j is k.
  always_comb begin
    case (cfg_q.mode)
      MODE_WIDEN:  wb_addr = vd_q + (k_q << flog_q) + ADDR_WIDTH'(turn_q);
      MODE_NARROW: wb_addr = vd_q + (k_q >> flog_q);
      default:     wb_addr = vd_q + k_q;
    endcase
    if (cfg_q.reduce) wb_addr = vd_q;
  end

  v_slot_be_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BE_W       (BE_W)
  ) u_be_gen (
    .idx       (idx),
    .start_idx (start_q),
    .end_idx   (end_q),
    .head_be   (head_q),
    .tail_be   (tail_q),
    .in_range  (in_range),
    .be        (be)
  );

  assign out_idx      = run ? idx : '0;
  assign out_turn     = run ? turn_q : '0;
  assign out_in_range = run && in_range;
  assign out_first    = run && (idx == start_q) && (turn_q == '0);
  assign out_wb_addr  = run ? wb_addr : '0;
  assign out_wb_be    = run ? be : '0;
  assign out_vs1      = run ? vs1_q + BANK_ADDR_WIDTH'(k_q >> ALIGN) : '0;
  assign out_vs2      = run ? vs2_q + BANK_ADDR_WIDTH'(k_q >> ALIGN) : '0;

endmodule
